// File: rtl/ps2_scan_decoder.sv
// ps2_scan_decoder: turns the PS/2 Set-2 scan byte stream into key events.
//
// Collapses E0 / F0 / E0 F0 prefixes into one {code, ext, release} event, swallows the
// eight-byte E1 pause sequence after emitting a single E1 event, and buffers events in a
// show-ahead FIFO. It also tracks the held state of the four arrow keys and the last
// make code.
//
// Ports:
//   CLOCK_50      in   system clock
//   resetn        in   asynchronous active-low reset
//   byte_valid    in   one-cycle strobe qualifying byte_data / frame_err
//   byte_data     in   received scan byte
//   frame_err     in   framing/parity error on this byte
//   event_ready   in   consumer accepts the head event
//   event_valid   out  FIFO not empty
//   event_code    out  head event code (0 when empty)
//   event_ext     out  head event had an E0 prefix
//   event_release out  head event had an F0 prefix
//   fifo_count    out  number of entries held
//   overflow      out  sticky: an event was dropped on a full FIFO
//   err_seen      out  sticky: a frame_err byte was received
//   arrows_held   out  [0] up, [1] down, [2] left, [3] right
//   last_make     out  code of the most recent make event
module ps2_scan_decoder #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     CLOCK_50,
  input  logic                     resetn,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_data,
  input  logic                     frame_err,
  input  logic                     event_ready,
  output logic                     event_valid,
  output logic [7:0]               event_code,
  output logic                     event_ext,
  output logic                     event_release,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic                     err_seen,
  output logic [3:0]               arrows_held,
  output logic [7:0]               last_make
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  typedef enum logic [2:0] {StIdle, StPreE0, StPreF0, StPreE0F0, StSkipPause} state_e;

  state_e state_q, state_d;
  logic [2:0] skip_q, skip_d;
  logic       emit;
  logic [7:0] ev_code;
  logic       ev_ext, ev_rel;

  // Make/break codes E0 12 and E0 59 are the "fake shift" bytes some keyboards insert.
  logic fake_shift;
  assign fake_shift = (byte_data == 8'h12) || (byte_data == 8'h59);

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    emit    = 1'b0;
    ev_code = byte_data;
    ev_ext  = 1'b0;
    ev_rel  = 1'b0;
    if (byte_valid) begin
      if (frame_err) begin
        state_d = StIdle;
        skip_d  = '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            case (byte_data)
              8'hE0: state_d = StPreE0;
              8'hF0: state_d = StPreF0;
              8'hE1: begin
                emit    = 1'b1;
                skip_d  = 3'd7;
                state_d = StSkipPause;
              end
              8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: ;
              default: emit = 1'b1;
            endcase
          end
          StPreE0: begin
            if (byte_data == 8'hF0) begin
              state_d = StPreE0F0;
            end else if (byte_data != 8'hE0) begin
              state_d = StIdle;
              emit    = !fake_shift;
              ev_ext  = 1'b1;
            end
          end
          StPreF0: begin
            state_d = StIdle;
            emit    = 1'b1;
            ev_rel  = 1'b1;
          end
          StPreE0F0: begin
            state_d = StIdle;
            emit    = !fake_shift;
            ev_ext  = 1'b1;
            ev_rel  = 1'b1;
          end
          StSkipPause: begin
            if (skip_q <= 3'd1) begin
              skip_d  = '0;
              state_d = StIdle;
            end else begin
              skip_d = skip_q - 3'd1;
            end
          end
          default: state_d = StIdle;
        endcase
      end
    end
  end

  // Arrow tracking and last make code.
  logic [3:0] arrow_hit;
  logic [3:0] arrows_q, arrows_d;
  logic [7:0] last_make_q, last_make_d;

  always_comb begin
    arrow_hit = 4'b0000;
    case (ev_code)
      8'h75: arrow_hit = 4'b0001;
      8'h72: arrow_hit = 4'b0010;
      8'h6B: arrow_hit = 4'b0100;
      8'h74: arrow_hit = 4'b1000;
      default: arrow_hit = 4'b0000;
    endcase
    arrows_d    = arrows_q;
    last_make_d = last_make_q;
    if (emit && ev_ext) begin
      arrows_d = ev_rel ? (arrows_q & ~arrow_hit) : (arrows_q | arrow_hit);
    end
    if (emit && !ev_rel) begin
      last_make_d = ev_code;
    end
  end

  // Event FIFO: entries are {ext, rel, code}.
  logic [9:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          pop, push_ok, full;
  logic          overflow_q, err_q;
  logic [9:0]    head;

  assign full    = (count_q == FullCount);
  assign pop     = event_valid && event_ready;
  assign push_ok = emit && (!full || pop);

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= {ev_ext, ev_rel, ev_code};
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      skip_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      err_q       <= 1'b0;
      arrows_q    <= '0;
      last_make_q <= '0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      count_q     <= count_d;
      arrows_q    <= arrows_d;
      last_make_q <= last_make_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      if (emit && !push_ok) overflow_q <= 1'b1;
      if (byte_valid && frame_err) err_q <= 1'b1;
    end
  end

  assign head          = mem_q[rd_ptr_q];
  assign event_valid   = (count_q != '0);
  assign event_code    = event_valid ? head[7:0] : 8'h00;
  assign event_release = event_valid ? head[8] : 1'b0;
  assign event_ext     = event_valid ? head[9] : 1'b0;
  assign fifo_count    = count_q;
  assign overflow      = overflow_q;
  assign err_seen      = err_q;
  assign arrows_held   = arrows_q;
  assign last_make     = last_make_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
module tb_ps2_scan_decoder;

  localparam int unsigned DEPTH = 8;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          CLOCK_50 = 1'b0;
  logic          resetn;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          frame_err;
  logic          event_ready;
  logic          event_valid;
  logic [7:0]    event_code;
  logic          event_ext;
  logic          event_release;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          err_seen;
  logic [3:0]    arrows_held;
  logic [7:0]    last_make;

  ps2_scan_decoder #(.DEPTH(DEPTH)) dut (
    .CLOCK_50      (CLOCK_50),
    .resetn        (resetn),
    .byte_valid    (byte_valid),
    .byte_data     (byte_data),
    .frame_err     (frame_err),
    .event_ready   (event_ready),
    .event_valid   (event_valid),
    .event_code    (event_code),
    .event_ext     (event_ext),
    .event_release (event_release),
    .fifo_count    (fifo_count),
    .overflow      (overflow),
    .err_seen      (err_seen),
    .arrows_held   (arrows_held),
    .last_make     (last_make)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Pending prefix bytes are kept as a list; the event is decided when a non-prefix
  // byte arrives, from which prefixes the list holds.
  logic [9:0] mq[$];      // {ext, rel, code}
  logic [7:0] pend[$];
  int         skip_left;
  logic       m_over, m_err;
  logic [3:0] m_arrows;
  logic [7:0] m_last;

  task automatic model_reset();
    mq.delete();
    pend.delete();
    skip_left = 0;
    m_over    = 1'b0;
    m_err     = 1'b0;
    m_arrows  = 4'b0;
    m_last    = 8'h00;
  endtask

  function automatic int arrow_index(input logic [7:0] c);
    case (c)
      8'h75:   return 0;
      8'h72:   return 1;
      8'h6B:   return 2;
      8'h74:   return 3;
      default: return -1;
    endcase
  endfunction

  // Decode one byte; returns 1 with the event if one is produced.
  function automatic logic model_byte(input logic [7:0] b, output logic [9:0] ev);
    logic ext, rel;
    ev = '0;
    if (skip_left > 0) begin
      skip_left--;
      return 1'b0;
    end
    if (pend.size() == 0) begin
      if (b == 8'hE0 || b == 8'hF0) begin
        pend.push_back(b);
        return 1'b0;
      end
      if (b == 8'hE1) begin
        skip_left = 7;
        ev = {2'b00, b};
        return 1'b1;
      end
      if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF}) return 1'b0;
      ev = {2'b00, b};
      return 1'b1;
    end
    ext = (pend[0] == 8'hE0);
    rel = 1'b0;
    foreach (pend[i]) if (pend[i] == 8'hF0) rel = 1'b1;
    if (ext && !rel && b == 8'hF0) begin
      pend.push_back(b);
      return 1'b0;
    end
    if (ext && !rel && b == 8'hE0) return 1'b0;
    pend.delete();
    if (ext && (b == 8'h12 || b == 8'h59)) return 1'b0;
    ev = {ext, rel, b};
    return 1'b1;
  endfunction

  task automatic model_edge(input logic v, input logic [7:0] d, input logic e, input logic r);
    logic       do_pop, emitted;
    logic [9:0] ev;
    int         ai;
    do_pop  = (mq.size() > 0) && r;
    emitted = 1'b0;
    ev      = '0;
    if (v) begin
      if (e) begin
        pend.delete();
        skip_left = 0;
        m_err     = 1'b1;
      end else begin
        emitted = model_byte(d, ev);
      end
    end
    if (do_pop) void'(mq.pop_front());
    if (emitted) begin
      if (mq.size() < DEPTH) mq.push_back(ev);
      else m_over = 1'b1;
      ai = arrow_index(ev[7:0]);
      if (ev[9] && ai >= 0) m_arrows[ai] = !ev[8];
      if (!ev[8]) m_last = ev[7:0];
    end
  endtask

  task automatic compare_model();
    logic [9:0] h;
    h = (mq.size() > 0) ? mq[0] : 10'h000;
    check("event_valid", 32'(event_valid), 32'(mq.size() > 0));
    check("event_code", 32'(event_code), 32'(h[7:0]));
    check("event_ext", 32'(event_ext), 32'(h[9]));
    check("event_release", 32'(event_release), 32'(h[8]));
    check("fifo_count", 32'(fifo_count), 32'(mq.size()));
    check("overflow", 32'(overflow), 32'(m_over));
    check("err_seen", 32'(err_seen), 32'(m_err));
    check("arrows_held", 32'(arrows_held), 32'(m_arrows));
    check("last_make", 32'(last_make), 32'(m_last));
  endtask

  // One clock: drive inputs, advance model, sample 1 time unit after the edge.
  task automatic step(input logic v, input logic [7:0] d, input logic e, input logic r);
    byte_valid  = v;
    byte_data   = d;
    frame_err   = e;
    event_ready = r;
    model_edge(v, d, e, r);
    @(posedge CLOCK_50);
    #1;
    compare_model();
    byte_valid = 1'b0;
    frame_err  = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic r);
    step(1'b1, d, 1'b0, r);
  endtask

  task automatic idle(input logic r);
    step(1'b0, 8'h00, 1'b0, r);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, 32'(event_valid), 32'(0));
    check({tag, "_code"}, 32'(event_code), 32'(0));
    check({tag, "_ext"}, 32'(event_ext), 32'(0));
    check({tag, "_rel"}, 32'(event_release), 32'(0));
    check({tag, "_count"}, 32'(fifo_count), 32'(0));
    check({tag, "_overflow"}, 32'(overflow), 32'(0));
    check({tag, "_err"}, 32'(err_seen), 32'(0));
    check({tag, "_arrows"}, 32'(arrows_held), 32'(0));
    check({tag, "_last"}, 32'(last_make), 32'(0));
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       r;
    logic       xv;
    logic [7:0] xc;
    logic       xe;
    logic       xr;
    logic [3:0] xa;
  } vec_t;

  vec_t tbl [11];

  initial begin
    // Stimulus table: consumer always ready, so each event is visible for one cycle.
    tbl[0]  = '{1'b1, 8'h1C, 1'b1, 1'b1, 8'h1C, 1'b0, 1'b0, 4'h0};
    tbl[1]  = '{1'b1, 8'hF0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0};
    tbl[2]  = '{1'b1, 8'h1C, 1'b1, 1'b1, 8'h1C, 1'b0, 1'b1, 4'h0};
    tbl[3]  = '{1'b1, 8'hE0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0};
    tbl[4]  = '{1'b1, 8'h75, 1'b1, 1'b1, 8'h75, 1'b1, 1'b0, 4'h1};
    tbl[5]  = '{1'b1, 8'h75, 1'b1, 1'b1, 8'h75, 1'b0, 1'b0, 4'h1};
    tbl[6]  = '{1'b1, 8'hE0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'h1};
    tbl[7]  = '{1'b1, 8'hF0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'h1};
    tbl[8]  = '{1'b1, 8'h75, 1'b1, 1'b1, 8'h75, 1'b1, 1'b1, 4'h0};
    tbl[9]  = '{1'b1, 8'h75, 1'b1, 1'b1, 8'h75, 1'b0, 1'b0, 4'h0};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0};

    resetn      = 1'b0;
    byte_valid  = 1'b0;
    byte_data   = 8'h00;
    frame_err   = 1'b0;
    event_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge CLOCK_50);
    #1;
    check_reset_values("reset");
    resetn = 1'b1;

    // Table-driven basic decode.
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].v, tbl[i].d, 1'b0, tbl[i].r);
      check($sformatf("tbl%0d_valid", i), 32'(event_valid), 32'(tbl[i].xv));
      check($sformatf("tbl%0d_code", i), 32'(event_code), 32'(tbl[i].xc));
      check($sformatf("tbl%0d_ext", i), 32'(event_ext), 32'(tbl[i].xe));
      check($sformatf("tbl%0d_rel", i), 32'(event_release), 32'(tbl[i].xr));
      check($sformatf("tbl%0d_arrows", i), 32'(arrows_held), 32'(tbl[i].xa));
    end
    check("tbl_last_make", 32'(last_make), 32'(8'h75));

    // Pause sequence then a make code: exactly two events.
    begin
      logic [7:0] pause_seq [9];
      pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C};
      for (int i = 0; i < 9; i++) send(pause_seq[i], 1'b0);
      check("pause_count", 32'(fifo_count), 32'(2));
      check("pause_head0", 32'(event_code), 32'(8'hE1));
      idle(1'b1);
      check("pause_head1", 32'({event_ext, event_release, event_code}), 32'(10'h01C));
      idle(1'b1);
      check("pause_empty", 32'(event_valid), 32'(0));
    end

    // Frame error discards the E0 prefix; ignored bytes yield nothing.
    step(1'b1, 8'hE0, 1'b1, 1'b0);
    check("ferr_err_seen", 32'(err_seen), 32'(1));
    send(8'h75, 1'b0);
    check("ferr_event", 32'({event_ext, event_release, event_code}), 32'(10'h075));
    send(8'hAA, 1'b0);
    send(8'hFA, 1'b0);
    check("ignored_count", 32'(fifo_count), 32'(1));
    idle(1'b1);

    // Overflow: nine pushes into eight entries, then drain in order.
    for (int i = 1; i <= 9; i++) send(8'(i), 1'b0);
    check("ovf_count", 32'(fifo_count), 32'(8));
    check("ovf_flag", 32'(overflow), 32'(1));
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("drain%0d", i), 32'(event_code), 32'(i));
      idle(1'b1);
    end
    check("drain_empty", 32'(event_valid), 32'(0));
    for (int i = 0; i < 8; i++) send(8'(8'h20 + i), 1'b0);
    send(8'h0A, 1'b1);
    check("fullpop_count", 32'(fifo_count), 32'(8));
    check("fullpop_head", 32'(event_code), 32'(8'h21));
    for (int i = 0; i < 8; i++) idle(1'b1);

    // Reset in the middle of an E0 F0 prefix.
    send(8'hE0, 1'b0);
    send(8'hF0, 1'b0);
    resetn = 1'b0;
    #2;
    model_reset();
    check_reset_values("midreset");
    @(posedge CLOCK_50);
    #1;
    resetn = 1'b1;
    send(8'h6B, 1'b0);
    check("midreset_event", 32'({event_ext, event_release, event_code}), 32'(10'h06B));
    idle(1'b1);

    // Randomised traffic against the model.
    begin
      logic [7:0] pool [12];
      logic       v, e, r;
      logic [7:0] d;
      int         ready_bias;
      pool = '{8'hE0, 8'hF0, 8'hE1, 8'h12, 8'h59, 8'h75, 8'h72, 8'h6B, 8'h74,
               8'hAA, 8'h1C, 8'h00};
      ready_bias = 2;
      for (int i = 0; i < 3000; i++) begin
        if (i % 200 == 0) ready_bias = int'($urandom_range(0, 3));
        v = ($urandom_range(0, 3) != 0);
        e = ($urandom_range(0, 49) == 0);
        r = (int'($urandom_range(0, 3)) < ready_bias);
        if ($urandom_range(0, 3) == 0) d = 8'($urandom);
        else d = pool[$urandom_range(0, 11)];
        step(v, d, e, r);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
